// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_pipe
//  Brief    : Registered, handshaked MIPS-subset decode stage with load-use
//             bubble insertion and flush. Optional FP decode: DECODE_FLOAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [REG_AW-1:0]  out_rs,
  output logic [REG_AW-1:0]  out_rt,
  output logic [REG_AW-1:0]  out_wreg,
  output logic [DATA_W-1:0]  out_imm_ext,
  output logic [4:0]         out_shamt,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic               out_regwrite,
  output logic               out_memread,
  output logic               out_memwrite,
  output logic               out_immreg,
  output logic               out_branch,
  output logic               out_bne,
  output logic               out_jump,
  output logic [25:0]        out_jtarget,
  output logic               out_float,
  output logic               out_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP1  = 6'h11;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

`ifdef DECODE_FLOAT_EN
  localparam logic [5:0] FN_FMUL  = 6'h02;
  localparam logic [4:0] FMT_FMUL = 5'b10000;
  localparam logic [4:0] FMT_MTC1 = 5'b00100;
`endif

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(4'b0011);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(4'b0100);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(4'b0111);
`ifdef DECODE_FLOAT_EN
  localparam logic [ALUOP_W-1:0] ALU_FMUL = ALUOP_W'(4'b0101);
  localparam logic [ALUOP_W-1:0] ALU_MTC1 = ALUOP_W'(4'b1010);
`endif

  localparam logic [REG_AW-1:0] LINK_REG = {REG_AW{1'b1}};

  // Raw instruction fields
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [15:0] imm;

  assign op    = in_instr[31:26];
  assign f_rs  = in_instr[25:21];
  assign f_rt  = in_instr[20:16];
  assign f_rd  = in_instr[15:11];
  assign imm   = in_instr[15:0];
  assign funct = in_instr[5:0];

  logic [REG_AW-1:0]  d_rs;
  logic [REG_AW-1:0]  d_rt;
  logic [REG_AW-1:0]  d_wreg;
  logic [DATA_W-1:0]  d_imm_ext;
  logic [ALUOP_W-1:0] d_aluop;
  logic               d_regwrite;
  logic               d_memread;
  logic               d_memwrite;
  logic               d_immreg;
  logic               d_branch;
  logic               d_bne;
  logic               d_jump;
  logic               d_illegal;
  logic               d_uses_rt;
`ifdef DECODE_FLOAT_EN
  logic               d_float;
`endif

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] imm_upper;

  assign d_rs      = REG_AW'(f_rs);
  assign d_rt      = REG_AW'(f_rt);
  assign imm_sext  = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext  = DATA_W'(imm);
  assign imm_upper = DATA_W'({imm, 16'h0000});

  always_comb begin
    d_wreg     = d_rt;
    d_imm_ext  = '0;
    d_aluop    = ALU_ADD;
    d_regwrite = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_immreg   = 1'b0;
    d_branch   = 1'b0;
    d_bne      = 1'b0;
    d_jump     = 1'b0;
    d_illegal  = 1'b0;
    d_uses_rt  = 1'b0;
`ifdef DECODE_FLOAT_EN
    d_float    = 1'b0;
`endif

    case (op)
      OP_RTYPE: begin
        d_wreg     = REG_AW'(f_rd);
        d_uses_rt  = 1'b1;
        d_regwrite = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: d_aluop = ALU_ADD;
          FN_SUB:          d_aluop = ALU_SUB;
          FN_AND:          d_aluop = ALU_AND;
          FN_OR:           d_aluop = ALU_OR;
          FN_SLL:          d_aluop = ALU_SLL;
          FN_SRL:          d_aluop = ALU_SRL;
          default:         d_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        d_regwrite = 1'b1;
        d_immreg   = 1'b1;
        d_imm_ext  = imm_sext;
      end
      OP_ANDI: begin
        d_regwrite = 1'b1;
        d_immreg   = 1'b1;
        d_imm_ext  = imm_zext;
        d_aluop    = ALU_AND;
      end
      OP_ORI: begin
        d_regwrite = 1'b1;
        d_immreg   = 1'b1;
        d_imm_ext  = imm_zext;
        d_aluop    = ALU_OR;
      end
      OP_LUI: begin
        d_regwrite = 1'b1;
        d_immreg   = 1'b1;
        d_imm_ext  = imm_upper;
        d_aluop    = ALU_LUI;
      end
      OP_LW: begin
        d_regwrite = 1'b1;
        d_memread  = 1'b1;
        d_immreg   = 1'b1;
        d_imm_ext  = imm_sext;
      end
      OP_SW: begin
        d_memwrite = 1'b1;
        d_immreg   = 1'b1;
        d_imm_ext  = imm_sext;
        d_uses_rt  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d_branch  = 1'b1;
        d_bne     = (op == OP_BNE);
        d_imm_ext = imm_sext;
        d_aluop   = ALU_SUB;
        d_uses_rt = 1'b1;
      end
      OP_J: begin
        d_jump = 1'b1;
      end
      OP_JAL: begin
        d_jump     = 1'b1;
        d_regwrite = 1'b1;
        d_wreg     = LINK_REG;
      end
      OP_COP1: begin
`ifdef DECODE_FLOAT_EN
        if (f_rs == FMT_FMUL && funct == FN_FMUL) begin
          d_regwrite = 1'b1;
          d_aluop    = ALU_FMUL;
          d_float    = 1'b1;
          d_wreg     = REG_AW'(f_rd);
        end else if (f_rs == FMT_MTC1) begin
          d_regwrite = 1'b1;
          d_aluop    = ALU_MTC1;
          d_float    = 1'b1;
          d_wreg     = REG_AW'(f_rd);
        end else begin
          d_illegal = 1'b1;
        end
`else
        d_illegal = 1'b1;
`endif
      end
      default: d_illegal = 1'b1;
    endcase

    // An unrecognised word still flows through the pipe but must not act.
    if (d_illegal) begin
      d_regwrite = 1'b0;
      d_memread  = 1'b0;
      d_memwrite = 1'b0;
      d_immreg   = 1'b0;
      d_branch   = 1'b0;
      d_bne      = 1'b0;
      d_jump     = 1'b0;
      d_aluop    = ALU_ADD;
      d_imm_ext  = '0;
`ifdef DECODE_FLOAT_EN
      d_float    = 1'b0;
`endif
    end
  end

  // Load-use: the held load's destination is read by the incoming word.
  logic hazard;
  logic accept;

  assign hazard = out_valid && out_memread && (out_wreg != '0) &&
                  ((d_rs == out_wreg) || (d_uses_rt && (d_rt == out_wreg)));
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs       <= '0;
      out_rt       <= '0;
      out_wreg     <= '0;
      out_imm_ext  <= '0;
      out_shamt    <= '0;
      out_aluop    <= '0;
      out_regwrite <= 1'b0;
      out_memread  <= 1'b0;
      out_memwrite <= 1'b0;
      out_immreg   <= 1'b0;
      out_branch   <= 1'b0;
      out_bne      <= 1'b0;
      out_jump     <= 1'b0;
      out_jtarget  <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs       <= d_rs;
      out_rt       <= d_rt;
      out_wreg     <= d_wreg;
      out_imm_ext  <= d_imm_ext;
      out_shamt    <= in_instr[10:6];
      out_aluop    <= d_aluop;
      out_regwrite <= d_regwrite;
      out_memread  <= d_memread;
      out_memwrite <= d_memwrite;
      out_immreg   <= d_immreg;
      out_branch   <= d_branch;
      out_bne      <= d_bne;
      out_jump     <= d_jump;
      out_jtarget  <= in_instr[25:0];
      out_illegal  <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_FLOAT_EN
  logic float_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      float_q <= 1'b0;
    end else if (accept) begin
      float_q <= d_float;
    end
  end

  assign out_float = float_q;
`else
  assign out_float = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage_pipe
//  Brief    : Directed and randomized checks of decode_stage_pipe against a
//             mnemonic-level reference model of the decode and handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs, out_rt, out_wreg, out_shamt;
  logic [31:0] out_imm_ext;
  logic [3:0]  out_aluop;
  logic        out_regwrite, out_memread, out_memwrite, out_immreg;
  logic        out_branch, out_bne, out_jump, out_float, out_illegal;
  logic [25:0] out_jtarget;

  decode_stage_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt), .out_wreg(out_wreg),
    .out_imm_ext(out_imm_ext), .out_shamt(out_shamt), .out_aluop(out_aluop),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_immreg(out_immreg), .out_branch(out_branch), .out_bne(out_bne),
    .out_jump(out_jump), .out_jtarget(out_jtarget), .out_float(out_float),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs, rt, wreg;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [3:0]  aluop;
    logic        regwrite, memread, memwrite, immreg, branch, bne, jump;
    logic [25:0] jt;
    logic        flt, ill;
  } bundle_t;

  localparam int K_ILL = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_OR = 4, K_SLL = 5,
                 K_SRL = 6, K_ADDI = 7, K_ANDI = 8, K_ORI = 9, K_LUI = 10, K_LW = 11,
                 K_SW = 12, K_BEQ = 13, K_BNE = 14, K_J = 15, K_JAL = 16,
                 K_FMUL = 17, K_MTC1 = 18;

  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;
  bundle_t     mdl;
  logic        mdl_v;
  logic [31:0] pc_ctr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input bundle_t obs, input bundle_t exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t observed();
    bundle_t b;
    b.pc = out_pc; b.rs = out_rs; b.rt = out_rt; b.wreg = out_wreg;
    b.imm = out_imm_ext; b.shamt = out_shamt; b.aluop = out_aluop;
    b.regwrite = out_regwrite; b.memread = out_memread; b.memwrite = out_memwrite;
    b.immreg = out_immreg; b.branch = out_branch; b.bne = out_bne; b.jump = out_jump;
    b.jt = out_jtarget; b.flt = out_float; b.ill = out_illegal;
    return b;
  endfunction

  function automatic int mnemonic(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21) return K_ADD;
      if (fn == 6'h22) return K_SUB;
      if (fn == 6'h24) return K_AND;
      if (fn == 6'h25) return K_OR;
      if (fn == 6'h00) return K_SLL;
      if (fn == 6'h02) return K_SRL;
      return K_ILL;
    end
    if (op == 6'h08 || op == 6'h09) return K_ADDI;
    if (op == 6'h0C) return K_ANDI;
    if (op == 6'h0D) return K_ORI;
    if (op == 6'h0F) return K_LUI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h05) return K_BNE;
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
`ifdef DECODE_FLOAT_EN
    if (op == 6'h11 && w[25:21] == 5'b10000 && fn == 6'h02) return K_FMUL;
    if (op == 6'h11 && w[25:21] == 5'b00100) return K_MTC1;
`endif
    return K_ILL;
  endfunction

  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    bundle_t b;
    int      k;
    logic [31:0] sx, zx;
    b = '0;
    k = mnemonic(w);
    sx = 32'($signed(w[15:0]));
    zx = {16'h0000, w[15:0]};
    b.pc = pc; b.rs = w[25:21]; b.rt = w[20:16]; b.shamt = w[10:6]; b.jt = w[25:0];
    b.wreg = (w[31:26] == 6'h00) ? w[15:11] : w[20:16];
    case (k)
      K_ADD:  b.regwrite = 1'b1;
      K_SUB:  begin b.regwrite = 1'b1; b.aluop = 4'd1; end
      K_AND:  begin b.regwrite = 1'b1; b.aluop = 4'd2; end
      K_OR:   begin b.regwrite = 1'b1; b.aluop = 4'd6; end
      K_SLL:  begin b.regwrite = 1'b1; b.aluop = 4'd3; end
      K_SRL:  begin b.regwrite = 1'b1; b.aluop = 4'd4; end
      K_ADDI: begin b.regwrite = 1'b1; b.immreg = 1'b1; b.imm = sx; end
      K_ANDI: begin b.regwrite = 1'b1; b.immreg = 1'b1; b.imm = zx; b.aluop = 4'd2; end
      K_ORI:  begin b.regwrite = 1'b1; b.immreg = 1'b1; b.imm = zx; b.aluop = 4'd6; end
      K_LUI:  begin b.regwrite = 1'b1; b.immreg = 1'b1; b.imm = zx << 16; b.aluop = 4'd7; end
      K_LW:   begin b.regwrite = 1'b1; b.memread = 1'b1; b.immreg = 1'b1; b.imm = sx; end
      K_SW:   begin b.memwrite = 1'b1; b.immreg = 1'b1; b.imm = sx; end
      K_BEQ:  begin b.branch = 1'b1; b.imm = sx; b.aluop = 4'd1; end
      K_BNE:  begin b.branch = 1'b1; b.bne = 1'b1; b.imm = sx; b.aluop = 4'd1; end
      K_J:    b.jump = 1'b1;
      K_JAL:  begin b.jump = 1'b1; b.regwrite = 1'b1; b.wreg = 5'd31; end
      K_FMUL: begin b.regwrite = 1'b1; b.aluop = 4'd5; b.flt = 1'b1; b.wreg = w[15:11]; end
      K_MTC1: begin b.regwrite = 1'b1; b.aluop = 4'd10; b.flt = 1'b1; b.wreg = w[15:11]; end
      default: b.ill = 1'b1;
    endcase
    return b;
  endfunction

  // Incoming word reads register r (rt counts only for R-type, sw, beq, bne)
  function automatic logic reads_reg(input logic [31:0] w, input logic [4:0] r);
    logic rt_src;
    rt_src = (w[31:26] == 6'h00) || (w[31:26] == 6'h2B) ||
             (w[31:26] == 6'h04) || (w[31:26] == 6'h05);
    return (w[25:21] == r) || (rt_src && w[20:16] == r);
  endfunction

  task automatic step(input logic v, input logic [31:0] w, input logic fl,
                      input logic ordy, input string tag);
    logic hz, rdy;
    in_valid = v; in_instr = w; in_pc = pc_ctr; flush = fl; out_ready = ordy;
    hz  = mdl_v && mdl.memread && (mdl.wreg != 5'd0) && reads_reg(w, mdl.wreg);
    rdy = !fl && !hz && (!mdl_v || ordy);
    #2;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    @(posedge clk);
    if (fl) mdl_v = 1'b0;
    else if (v && rdy) begin
      mdl_v = 1'b1;
      mdl   = ref_decode(w, pc_ctr);
    end else if (ordy) mdl_v = 1'b0;
    if (!fl && v && rdy) pc_ctr = pc_ctr + 32'd4;
    #1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(mdl_v));
    if (mdl_v) check_b({tag, ".bundle"}, observed(), mdl);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd, sh, fmt;
    logic [5:0]  fn, op;
    int          sel;
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 7));
    sh  = 5'($urandom);
    sel = int'($urandom_range(0, 19));
    if (sel < 5) begin
      case ($urandom_range(0, 8))
        0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;  3: fn = 6'h24;
        4: fn = 6'h25;  5: fn = 6'h00;  6: fn = 6'h02;  7: fn = 6'h2A;
        default: fn = 6'($urandom);
      endcase
      return {6'h00, rs, rt, rd, sh, fn};
    end else if (sel < 15) begin
      case ($urandom_range(0, 10))
        0: op = 6'h08;  1: op = 6'h09;  2: op = 6'h0C;  3: op = 6'h0D;
        4: op = 6'h0F;  5: op = 6'h23;  6: op = 6'h2B;  7: op = 6'h04;
        8: op = 6'h05;  default: op = 6'h23;
      endcase
      return {op, rs, rt, 16'($urandom)};
    end else if (sel < 17) begin
      return {(sel == 15) ? 6'h02 : 6'h03, 26'($urandom)};
    end else if (sel < 19) begin
      case ($urandom_range(0, 2))
        0: fmt = 5'b10000;  1: fmt = 5'b00100;  default: fmt = 5'($urandom);
      endcase
      fn = ($urandom_range(0, 1) == 0) ? 6'h02 : 6'($urandom);
      return {6'h11, fmt, rt, rd, sh, fn};
    end
    return $urandom;
  endfunction

  initial begin
    logic exp_ill, exp_flt;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    mdl = '0; mdl_v = 1'b0; pc_ctr = 32'h0000_1000;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.out_valid", 64'(out_valid), 64'(0));
    check_b("reset.bundle", observed(), '0);
    #1;
    check("reset.in_ready", 64'(in_ready), 64'(1));

    // add $3,$1,$2
    step(1'b1, 32'h0022_1820, 1'b0, 1'b1, "add");
    check("add.regwrite", 64'(out_regwrite), 64'(1));
    check("add.wreg", 64'(out_wreg), 64'(3));
    check("add.aluop", 64'(out_aluop), 64'(0));
    check("add.immreg", 64'(out_immreg), 64'(0));

    // Immediate extension
    step(1'b1, 32'h2005_FFFF, 1'b0, 1'b1, "addi");
    check("addi.imm", 64'(out_imm_ext), 64'(32'hFFFF_FFFF));
    step(1'b1, 32'h3005_FFFF, 1'b0, 1'b1, "andi");
    check("andi.imm", 64'(out_imm_ext), 64'(32'h0000_FFFF));
    step(1'b1, 32'h3C05_8001, 1'b0, 1'b1, "lui");
    check("lui.imm", 64'(out_imm_ext), 64'(32'h8001_0000));

    // Load-use: exactly one bubble
    step(1'b1, 32'h8C24_0000, 1'b0, 1'b1, "lw");
    step(1'b1, 32'h0084_3020, 1'b0, 1'b1, "lu.stall");
    check("lu.bubble", 64'(out_valid), 64'(0));
    step(1'b1, 32'h0084_3020, 1'b0, 1'b1, "lu.accept");
    check("lu.after", 64'({out_valid, out_wreg}), 64'({1'b1, 5'd6}));

    // jal held under backpressure
    step(1'b1, 32'h0C00_0010, 1'b0, 1'b1, "jal");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h2005_0001, 1'b0, 1'b0, "jal.hold");
      check("jal.wreg", 64'(out_wreg), 64'(31));
      check("jal.jt", 64'(out_jtarget), 64'(26'h10));
    end

    // Flush beats accept with a held sw
    step(1'b1, 32'hAC22_0004, 1'b0, 1'b1, "sw");
    step(1'b1, 32'h2005_0002, 1'b1, 1'b0, "flush");
    check("flush.valid", 64'(out_valid), 64'(0));
    step(1'b0, 32'h0, 1'b0, 1'b1, "flush.idle");
    check("flush.noaccept", 64'(out_valid), 64'(0));

    // fmul encoding
`ifdef DECODE_FLOAT_EN
    exp_ill = 1'b0; exp_flt = 1'b1;
`else
    exp_ill = 1'b1; exp_flt = 1'b0;
`endif
    step(1'b1, 32'h4602_0002, 1'b0, 1'b1, "fmul");
    check("fmul.illegal", 64'(out_illegal), 64'(exp_ill));
    check("fmul.float", 64'(out_float), 64'(exp_flt));

    // Word zero is a legal sll nop
    step(1'b1, 32'h0000_0000, 1'b0, 1'b1, "nop");
    check("nop.illegal", 64'(out_illegal), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
